// File: rtl/decode_stage.sv
// decode_stage: ARM instruction decode and operand issue.
// Decodes the fetched word, drives the register-file read ports, and registers
// the decoded fields so they line up with the one-cycle-delayed read data.
// A shifting destination scoreboard blocks read-after-write hazards until the
// producer's result is visible in the register file.
//
// Handshake: a fetch is consumed on a rising edge where fetch_valid and
// fetch_ready are both 1; fetch_ready never depends on fetch_valid except
// through hazard, and fetch must hold fetch_inst/fetch_pc stable until consumed.

`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef REG_COUNT_L2
`define REG_COUNT_L2 4
`endif

module decode_stage #(
  parameter int SB_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     fetch_valid,
  input  logic [`BIT_WIDTH-1:0]    fetch_inst,
  input  logic [`BIT_WIDTH-1:0]    fetch_pc,
  output logic                     fetch_ready,
  input  logic                     stall_in,
  input  logic                     flush,
  output logic [`REG_COUNT_L2-1:0] read_addr1,
  output logic [`REG_COUNT_L2-1:0] read_addr2,
  output logic                     dec_valid,
  output logic [`BIT_WIDTH-1:0]    dec_inst,
  output logic [`BIT_WIDTH-1:0]    dec_pc,
  output logic [`REG_COUNT_L2-1:0] dec_rd,
  output logic                     dec_writes_rd,
  output logic                     dec_is_dp,
  output logic                     dec_is_mem,
  output logic                     dec_is_branch,
  output logic                     hazard
);

  localparam int RW = `REG_COUNT_L2;
  localparam logic [RW-1:0] PC_REG = '1;
  localparam logic [RW-1:0] LR_REG = RW'(14);

  typedef struct packed {
    logic          is_dp;
    logic          is_mem;
    logic          is_branch;
    logic          src1_v;
    logic [RW-1:0] src1;
    logic          src2_v;
    logic [RW-1:0] src2;
    logic          wr;
    logic [RW-1:0] rd;
  } dec_t;

  // Field extraction shared by the live fetch word and the held dec_inst.
  function automatic dec_t decode(input logic [`BIT_WIDTH-1:0] inst);
    dec_t d;
    d = '0;
    d.is_dp     = (inst[27:26] == 2'b00);
    d.is_mem    = (inst[27:26] == 2'b01);
    d.is_branch = (inst[27:25] == 3'b101);
    if (d.is_dp) begin
      d.src1_v = 1'b1;
      d.src1   = inst[19:16];
      d.src2_v = ~inst[25];
      d.src2   = inst[3:0];
      // TST/TEQ/CMP/CMN (opcode 10xx) only set flags
      d.wr     = (inst[24:23] != 2'b10);
      d.rd     = inst[15:12];
    end else if (d.is_mem) begin
      d.src1_v = 1'b1;
      d.src1   = inst[19:16];
      d.src2_v = ~inst[20];
      d.src2   = inst[15:12];
      d.wr     = inst[20];
      d.rd     = inst[15:12];
    end else if (d.is_branch) begin
      d.wr     = inst[24];
      d.rd     = LR_REG;
    end
    return d;
  endfunction

  dec_t          fd;
  dec_t          hd;
  logic          accept;
  logic          slot_new_v;
  logic [SB_DEPTH-1:0] sb_v;
  logic [RW-1:0] sb_a [SB_DEPTH];

  // Fields such as condition and immediates are carried in dec_inst only.
  logic unused_bits;
  assign unused_bits = ^{fetch_inst[31:28], fetch_inst[11:4],
                         dec_inst[31:28], dec_inst[11:4]};

  assign fd = decode(fetch_inst);
  assign hd = decode(dec_inst);

  // Read ports follow the fetch word, or the held instruction while stalled.
  always_comb begin
    read_addr1 = '0;
    read_addr2 = '0;
    if (stall_in) begin
      if (hd.src1_v) read_addr1 = hd.src1;
      if (hd.src2_v) read_addr2 = hd.src2;
    end else begin
      if (fd.src1_v) read_addr1 = fd.src1;
      if (fd.src2_v) read_addr2 = fd.src2;
    end
  end

  // RAW check of the fetch word's sources against every live scoreboard slot.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_v[i] && fd.src1_v && (fd.src1 != PC_REG) && (fd.src1 == sb_a[i]))
        hazard = 1'b1;
      if (sb_v[i] && fd.src2_v && (fd.src2 != PC_REG) && (fd.src2 == sb_a[i]))
        hazard = 1'b1;
    end
    hazard = hazard & fetch_valid;
  end

  assign fetch_ready = nreset & ~flush & ~stall_in & ~hazard;
  assign accept      = fetch_valid & fetch_ready;
  // PC writes redirect through flush, so r15 never occupies a slot.
  assign slot_new_v  = accept & fd.wr & (fd.rd != PC_REG);

  // Decode register and scoreboard: reset > flush > stall > accept > bubble.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      dec_valid     <= 1'b0;
      dec_inst      <= '0;
      dec_pc        <= '0;
      dec_rd        <= '0;
      dec_writes_rd <= 1'b0;
      dec_is_dp     <= 1'b0;
      dec_is_mem    <= 1'b0;
      dec_is_branch <= 1'b0;
      sb_v          <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_a[i] <= '0;
    end else if (flush) begin
      dec_valid <= 1'b0;
      sb_v      <= '0;
    end else if (!stall_in) begin
      sb_v    <= {sb_v[SB_DEPTH-2:0], slot_new_v};
      sb_a[0] <= fd.rd;
      for (int i = 1; i < SB_DEPTH; i++) sb_a[i] <= sb_a[i-1];
      if (accept) begin
        dec_valid     <= 1'b1;
        dec_inst      <= fetch_inst;
        dec_pc        <= fetch_pc;
        dec_rd        <= fd.rd;
        dec_writes_rd <= fd.wr;
        dec_is_dp     <= fd.is_dp;
        dec_is_mem    <= fd.is_mem;
        dec_is_branch <= fd.is_branch;
      end else begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, throughput, RAW stalls, load/store
// decode, downstream stall, flush and reset during a hazard.
module tb_decode_stage;

  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD r1,r2,r3
  localparam logic [31:0] I_CMP   = 32'hE1510002; // CMP r1,r2
  localparam logic [31:0] I_B     = 32'hEA000000; // B
  localparam logic [31:0] I_SUB   = 32'hE0414005; // SUB r4,r1,r5
  localparam logic [31:0] I_BL    = 32'hEB000000; // BL
  localparam logic [31:0] I_STR14 = 32'hE580E000; // STR r14,[r0]
  localparam logic [31:0] I_LDR   = 32'hE5910000; // LDR r0,[r1]
  localparam logic [31:0] I_STR0  = 32'hE5810000; // STR r0,[r1]
  localparam logic [31:0] I_ADD64 = 32'hE0846004; // ADD r6,r4,r4
  localparam logic [31:0] I_ADD76 = 32'hE0867000; // ADD r7,r6,r0

  logic        clk = 1'b0;
  logic        nreset;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        stall_in;
  logic        flush;
  logic [3:0]  read_addr1;
  logic [3:0]  read_addr2;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [3:0]  dec_rd;
  logic        dec_writes_rd;
  logic        dec_is_dp;
  logic        dec_is_mem;
  logic        dec_is_branch;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  decode_stage #(.SB_DEPTH(3)) dut (
    .clk(clk), .nreset(nreset),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .stall_in(stall_in), .flush(flush),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_rd(dec_rd), .dec_writes_rd(dec_writes_rd),
    .dec_is_dp(dec_is_dp), .dec_is_mem(dec_is_mem), .dec_is_branch(dec_is_branch),
    .hazard(hazard)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_inst  = inst;
    fetch_pc    = pc;
    #1;
  endtask

  // Consumer held off by a producer one edge earlier: three bubbles, then free.
  task automatic hazard_wait(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_hazard"}, {31'b0, hazard}, 32'd1);
      chk({tag, "_ready"}, {31'b0, fetch_ready}, 32'd0);
      tick();
      chk({tag, "_bubble"}, {31'b0, dec_valid}, 32'd0);
    end
    chk({tag, "_hazard_clear"}, {31'b0, hazard}, 32'd0);
    chk({tag, "_ready_again"}, {31'b0, fetch_ready}, 32'd1);
  endtask

  initial begin
    // Reset with a valid fetch pending
    nreset = 1'b0; stall_in = 1'b0; flush = 1'b0;
    present(I_ADD, 32'h0);
    tick(); tick();
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    chk("rst_dec_inst", dec_inst, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_rd", {28'b0, dec_rd}, 32'd0);
    chk("rst_writes", {31'b0, dec_writes_rd}, 32'd0);
    chk("rst_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'd0);
    chk("rst_hazard", {31'b0, hazard}, 32'd0);

    // Independent stream CMP, B, ADD: one per cycle
    nreset = 1'b1;
    present(I_CMP, 32'h100);
    chk("cmp_ready", {31'b0, fetch_ready}, 32'd1);
    chk("cmp_raddr", {24'b0, read_addr1, read_addr2}, 32'h12);
    tick();
    present(I_B, 32'h104);
    chk("cmp_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("cmp_dec_pc", dec_pc, 32'h100);
    chk("cmp_writes", {31'b0, dec_writes_rd}, 32'd0);
    chk("cmp_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b100);
    chk("b_raddr", {24'b0, read_addr1, read_addr2}, 32'h00);
    chk("b_ready", {31'b0, fetch_ready}, 32'd1);
    tick();
    present(I_ADD, 32'h108);
    chk("b_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("b_dec_pc", dec_pc, 32'h104);
    chk("b_writes", {31'b0, dec_writes_rd}, 32'd0);
    chk("b_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b001);
    chk("add_raddr", {24'b0, read_addr1, read_addr2}, 32'h23);
    chk("add_ready", {31'b0, fetch_ready}, 32'd1);
    tick();

    // ADD r1 then SUB reading r1
    present(I_SUB, 32'h10C);
    chk("add_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("add_dec_rd", {28'b0, dec_rd}, 32'd1);
    chk("add_writes", {31'b0, dec_writes_rd}, 32'd1);
    chk("add_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b100);
    chk("sub_raddr", {24'b0, read_addr1, read_addr2}, 32'h15);
    hazard_wait("sub");
    tick();
    chk("sub_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("sub_dec_inst", dec_inst, I_SUB);
    chk("sub_dec_rd", {28'b0, dec_rd}, 32'd4);

    // BL (writes r14) then STR r14 via src2
    present(I_BL, 32'h110);
    chk("bl_ready", {31'b0, fetch_ready}, 32'd1);
    tick();
    present(I_STR14, 32'h114);
    chk("bl_dec_rd", {28'b0, dec_rd}, 32'd14);
    chk("bl_writes", {31'b0, dec_writes_rd}, 32'd1);
    chk("bl_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b001);
    chk("str14_raddr", {24'b0, read_addr1, read_addr2}, 32'h0E);
    hazard_wait("str14");
    tick();
    chk("str14_dec_inst", dec_inst, I_STR14);
    chk("str14_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b010);

    // Load then dependent store
    present(I_LDR, 32'h118);
    chk("ldr_raddr", {24'b0, read_addr1, read_addr2}, 32'h10);
    chk("ldr_ready", {31'b0, fetch_ready}, 32'd1);
    tick();
    present(I_STR0, 32'h11C);
    chk("ldr_dec_rd", {28'b0, dec_rd}, 32'd0);
    chk("ldr_writes", {31'b0, dec_writes_rd}, 32'd1);
    chk("ldr_flags", {29'b0, dec_is_dp, dec_is_mem, dec_is_branch}, 32'b010);
    chk("str0_raddr", {24'b0, read_addr1, read_addr2}, 32'h10);
    hazard_wait("str0");
    tick();
    chk("str0_dec_inst", dec_inst, I_STR0);
    chk("str0_writes", {31'b0, dec_writes_rd}, 32'd0);

    // Downstream stall for two edges while ADD sits in decode
    present(I_ADD, 32'h120);
    tick();
    stall_in = 1'b1;
    present(I_B, 32'h124);
    chk("stall_raddr", {24'b0, read_addr1, read_addr2}, 32'h23);
    chk("stall_ready", {31'b0, fetch_ready}, 32'd0);
    chk("stall_dec_inst", dec_inst, I_ADD);
    tick();
    chk("stall1_dec_inst", dec_inst, I_ADD);
    chk("stall1_dec_pc", dec_pc, 32'h120);
    chk("stall1_dec_valid", {31'b0, dec_valid}, 32'd1);
    tick();
    chk("stall2_dec_pc", dec_pc, 32'h120);
    chk("stall2_raddr", {24'b0, read_addr1, read_addr2}, 32'h23);
    stall_in = 1'b0;
    #1;
    chk("release_ready", {31'b0, fetch_ready}, 32'd1);
    chk("release_raddr", {24'b0, read_addr1, read_addr2}, 32'h00);
    tick();
    chk("release_dec_inst", dec_inst, I_B);
    chk("release_dec_pc", dec_pc, 32'h124);

    // Flush during a hazard bubble clears the scoreboard
    present(I_ADD, 32'h130);
    tick();
    present(I_SUB, 32'h134);
    chk("fl_hazard", {31'b0, hazard}, 32'd1);
    tick();
    chk("fl_bubble", {31'b0, dec_valid}, 32'd0);
    flush = 1'b1;
    #1;
    chk("fl_ready", {31'b0, fetch_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("fl_hazard_clear", {31'b0, hazard}, 32'd0);
    chk("fl_ready_after", {31'b0, fetch_ready}, 32'd1);
    tick();
    chk("fl_sub_valid", {31'b0, dec_valid}, 32'd1);
    chk("fl_sub_pc", dec_pc, 32'h134);

    // Flush and stall together: flush wins, fetch not consumed
    stall_in = 1'b1; flush = 1'b1;
    present(I_B, 32'h140);
    chk("fs_ready", {31'b0, fetch_ready}, 32'd0);
    tick();
    stall_in = 1'b0; flush = 1'b0;
    present(I_ADD64, 32'h144);
    chk("fs_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("fs_hazard_r4", {31'b0, hazard}, 32'd0);
    tick();
    chk("fs_add64_inst", dec_inst, I_ADD64);

    // Reset in the middle of a hazard
    present(I_ADD76, 32'h148);
    chk("rh_hazard", {31'b0, hazard}, 32'd1);
    nreset = 1'b0;
    #1;
    chk("rh_ready_low", {31'b0, fetch_ready}, 32'd0);
    tick();
    chk("rh_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rh_dec_inst", dec_inst, 32'd0);
    chk("rh_dec_rd", {28'b0, dec_rd}, 32'd0);
    nreset = 1'b1;
    #1;
    chk("rh_hazard_clear", {31'b0, hazard}, 32'd0);
    chk("rh_ready", {31'b0, fetch_ready}, 32'd1);
    tick();
    chk("rh_accept_inst", dec_inst, I_ADD76);
    chk("rh_accept_pc", dec_pc, 32'h148);

    fetch_valid = 1'b0;
    tick();
    chk("idle_bubble", {31'b0, dec_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-issue stage. It accepts 32-bit ARM instructions from fetch and drives the register file read addresses. It registers the decoded fields so they emerge on the same cycle as the register file's one-cycle-delayed read values. A destination scoreboard inserts bubbles on read-after-write hazards; stall and flush from downstream are honoured.

## Interface
- SB_DEPTH, 3: number of in-flight destination slots tracked; equals cycles from decode output to register-file write visibility.
- clk  in  1  clock, all state on rising edge
- nreset  in  1  synchronous reset, active-low
- fetch_valid  in  1  fetch_inst/fetch_pc valid
- fetch_inst  in  `BIT_WIDTH  instruction word
- fetch_pc  in  `BIT_WIDTH  address of fetch_inst
- fetch_ready  out  1  instruction accepted on this edge when fetch_valid & fetch_ready
- stall_in  in  1  downstream cannot take dec_* this cycle; hold outputs
- flush  in  1  discard decoded instruction and scoreboard (branch taken)
- read_addr1, read_addr2  out  `REG_COUNT_L2  register file read addresses (combinational)
- dec_valid  out  1  dec_* hold a live instruction
- dec_inst, dec_pc  out  `BIT_WIDTH  registered copy of accepted instruction/PC
- dec_rd  out  `REG_COUNT_L2  destination register
- dec_writes_rd  out  1  instruction writes a general register
- dec_is_dp, dec_is_mem, dec_is_branch  out  1  class one-hots (all 0 = undefined)
- hazard  out  1  RAW hazard detected this cycle (debug/perf)

## Operation
- Decode of fetch_inst (combinational): class from bits[27:25]: 00x = dp, 01x = mem, 101 = branch, else undefined. Rn = [19:16], Rd = [15:12], Rm = [3:0].
- Sources:
  - dp: src1 = Rn; src2 = Rm if bit25 = 0, else none.
  - mem: src1 = Rn; src2 = Rd if store (bit20 = 0), else none.
  - branch/undefined: none.
- Destination:
  - dp writes Rd unless opcode[24:21] is 1000–1011 (TST/TEQ/CMP/CMN).
  - LDR writes Rd.
  - BL (bit24 = 1) writes r14.
  - B, STR and undefined write nothing.
  - Rd = r15 is not tracked (PC write; flush handles it).
- read_addr1/2 = src1/src2 of fetch_inst (0 when none). While stall_in = 1 they instead present the held dec_inst's sources, so the register file output stays aligned with dec_*.
- Scoreboard: SB_DEPTH slots {valid, addr}. On every edge with stall_in = 0 it shifts by one. Slot0 receives the destination of the instruction accepted that edge, or invalid when none is accepted or it writes nothing. Oldest slot drops.
- hazard = fetch_valid & any valid source ≠ r15 matching any valid slot address.
- fetch_ready = nreset & !flush & !stall_in & !hazard.
- Edge priority: reset > flush > stall_in > accept > bubble.
  - flush: dec_valid ← 0, all slots invalid, nothing accepted.
  - stall_in: all dec_* and slots hold.
  - accept: dec_* ← decoded fetch, dec_valid ← 1.
  - otherwise: dec_valid ← 0 (bubble); other dec_* don't-care.

## Timing
- Reset values: dec_valid 0, dec_inst 0, dec_pc 0, dec_rd 0, dec_writes_rd 0, class flags 0, all slots invalid.
- fetch_ready is 0 while nreset = 0. read_addr* and hazard are combinational and follow inputs.
- Latency: instruction accepted at edge t has dec_valid = 1 from t to t+1. Register file read values for it are valid in that same cycle.
- Throughput: one instruction per cycle with no hazards.
- Dependent back-to-back instruction: SB_DEPTH bubble cycles, accepted on the (SB_DEPTH+1)th edge after the producer.
- A source equal to r15 never causes a hazard.
- Simultaneous flush and stall_in: flush wins.
- Simultaneous flush and fetch_valid: the fetch is not consumed.
- Reset asserted mid-stall or mid-hazard: all state clears on that edge; the held instruction is lost.
- stall_in during a hazard: scoreboard frozen, hazard persists.

## Test plan
- Reset: nreset = 0 for 2 cycles with fetch_valid = 1, 0xE0821003 → dec_valid = 0, fetch_ready = 0, all dec_* = 0.
- Independent stream: ADD r1,r2,r3 (0xE0821003), CMP r1,r2 (0xE1510002), B (0xEA000000) on consecutive cycles. Required:
  - no bubbles.
  - read_addr = (2,3), (1,2), (0,0).
  - dec_writes_rd = 1, 0, 0.
  - class flags dp, dp, branch.
- RAW hazard: ADD r1,r2,r3 then SUB r4,r1,r5 (0xE0414005) → hazard = 1 and fetch_ready = 0 for exactly 3 cycles, dec_valid = 0 for those 3 cycles, SUB appears on the 4th. Repeat with BL (0xEB000000) then STR r14,[r0] (0xE580E000) → same 3-cycle stall via src2 = r14.
- Load/store: LDR r0,[r1] (0xE5910000) → read_addr1 = 1, dec_rd = 0, dec_writes_rd = 1. STR r0,[r1] (0xE5810000) → read_addr2 = 0, dec_writes_rd = 0.
- Stall: stall_in = 1 for 2 cycles while ADD is in dec → dec_* unchanged, read_addr = (2,3), fetch_ready = 0. Next instruction is accepted the cycle after release.
- Flush: flush during a hazard bubble → dec_valid = 0, slots cleared. The pending SUB is accepted on the following edge with no remaining stall.
